// File: rtl/uart_rx.sv
// 8N1-style UART receiver using an external oversampling tick.
// Delivers words on a valid/ready handshake and flags framing and overrun errors.
`timescale 1ns / 1ps

module uart_rx #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 rx_i,
  input  logic                 rx_ready_i,
  output logic [DATA_BITS-1:0] rx_data_o,
  output logic                 rx_valid_o,
  output logic                 frame_error_o,
  output logic                 overrun_o,
  output logic                 rx_busy_o
);

  localparam int unsigned SW = $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DATA_BITS);

  localparam logic [SW-1:0] SHalf = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] SFull = SW'(OVERSAMPLE - 1);
  localparam logic [NW-1:0] NLast = NW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  state_e                 state_q;
  logic                   rx_meta_q;
  logic                   rx_s_q;
  logic [SW-1:0]          s_cnt_q;
  logic [NW-1:0]          n_cnt_q;
  logic [DATA_BITS-1:0]   shreg_q;
  logic [DATA_BITS-1:0]   rx_data_q;
  logic                   rx_valid_q;
  logic                   frame_error_q;
  logic                   overrun_q;
  logic                   rx_busy_q;

  // Idle-high synchronizer so reset never looks like a start bit.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= StIdle;
      s_cnt_q       <= '0;
      n_cnt_q       <= '0;
      shreg_q       <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      rx_busy_q     <= 1'b0;
    end else begin
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      if (rx_valid_q && rx_ready_i) begin
        rx_valid_q <= 1'b0;
      end

      unique case (state_q)
        StIdle: begin
          if (!rx_s_q) begin
            state_q   <= StStart;
            rx_busy_q <= 1'b1;
            s_cnt_q   <= '0;
          end
        end

        StStart: begin
          if (tick_i) begin
            if (s_cnt_q == SHalf) begin
              if (rx_s_q) begin
                // Start bit did not hold to mid-bit: treat as a glitch.
                state_q   <= StIdle;
                rx_busy_q <= 1'b0;
              end else begin
                state_q <= StData;
                s_cnt_q <= '0;
                n_cnt_q <= '0;
              end
            end else begin
              s_cnt_q <= s_cnt_q + SW'(1);
            end
          end
        end

        StData: begin
          if (tick_i) begin
            if (s_cnt_q == SFull) begin
              s_cnt_q <= '0;
              shreg_q <= {rx_s_q, shreg_q[DATA_BITS-1:1]};
              if (n_cnt_q == NLast) begin
                state_q <= StStop;
              end else begin
                n_cnt_q <= n_cnt_q + NW'(1);
              end
            end else begin
              s_cnt_q <= s_cnt_q + SW'(1);
            end
          end
        end

        StStop: begin
          if (tick_i) begin
            if (s_cnt_q == SFull) begin
              state_q   <= StIdle;
              rx_busy_q <= 1'b0;
              if (rx_s_q) begin
                rx_data_q  <= shreg_q;
                rx_valid_q <= 1'b1;
                // A same-cycle handshake frees the slot, so only an unconsumed word overruns.
                overrun_q  <= rx_valid_q && !rx_ready_i;
              end else begin
                frame_error_q <= 1'b1;
              end
            end else begin
              s_cnt_q <= s_cnt_q + SW'(1);
            end
          end
        end

        default: begin
          state_q   <= StIdle;
          rx_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_data_o     = rx_data_q;
  assign rx_valid_o    = rx_valid_q;
  assign frame_error_o = frame_error_q;
  assign overrun_o     = overrun_q;
  assign rx_busy_o     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed frames push expected events, a monitor
// pops them whenever the DUT delivers a word or pulses an error flag.
`timescale 1ns / 1ps

module tb_uart_rx;

  localparam int BitClk = 64;  // 16 ticks per bit, one tick every 4 clk

  localparam int KData = 0;
  localparam int KFerr = 1;
  localparam int KOvr  = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
  } ev_t;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       tick_i;
  logic       rx_i;
  logic       rx_ready_i;
  logic [7:0] rx_data_o;
  logic       rx_valid_o;
  logic       frame_error_o;
  logic       overrun_o;
  logic       rx_busy_o;

  ev_t exp_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;

  uart_rx #(
    .DATA_BITS (8),
    .OVERSAMPLE(16)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .tick_i       (tick_i),
    .rx_i         (rx_i),
    .rx_ready_i   (rx_ready_i),
    .rx_data_o    (rx_data_o),
    .rx_valid_o   (rx_valid_o),
    .frame_error_o(frame_error_o),
    .overrun_o    (overrun_o),
    .rx_busy_o    (rx_busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    tick_i = 1'b0;
    forever begin
      repeat (3) @(negedge clk_i);
      tick_i = 1'b1;
      @(negedge clk_i);
      tick_i = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input logic [7:0] data);
    ev_t e;
    e.kind = kind;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic pop_check(input string name, input int kind, input logic [7:0] data);
    ev_t e;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: unexpected event data=0x%0h, expected no event", name, data);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.data !== data) begin
        n_fail++;
        $display("FAIL %s: got kind %0d data 0x%0h, expected kind %0d data 0x%0h",
                 name, kind, data, e.kind, e.data);
      end
    end
  endtask

  // Monitor: outputs sampled on the falling edge, away from the active edge.
  always @(negedge clk_i) begin
    if (!reset_i) begin
      if (rx_valid_o && rx_ready_i) pop_check("deliver", KData, rx_data_o);
      if (frame_error_o) pop_check("frame_error", KFerr, 8'h00);
      if (overrun_o) pop_check("overrun", KOvr, rx_data_o);
    end
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_len);
    rx_i = 1'b0;
    repeat (BitClk) @(negedge clk_i);
    for (int i = 0; i < 8; i++) begin
      rx_i = b[i];
      repeat (BitClk) @(negedge clk_i);
    end
    rx_i = stop_bit;
    repeat (stop_len) @(negedge clk_i);
    rx_i = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      @(negedge clk_i);
      n++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk_i);
    #1 rx_ready_i = v;
  endtask

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset_i    = 1'b1;
    rx_i       = 1'b1;
    rx_ready_i = 1'b1;
    repeat (5) @(negedge clk_i);
    check("reset rx_data", rx_data_o, 0);
    check("reset rx_valid", rx_valid_o, 0);
    check("reset frame_error", frame_error_o, 0);
    check("reset overrun", overrun_o, 0);
    check("reset rx_busy", rx_busy_o, 0);
    reset_i = 1'b0;
    repeat (10) @(negedge clk_i);

    // Single word
    expect_ev(KData, 8'hA5);
    send_frame(8'hA5, 1'b1, BitClk);
    repeat (20) @(negedge clk_i);
    drain("single word");
    check("idle after frame", rx_busy_o, 0);

    // Back-to-back words
    expect_ev(KData, 8'h00);
    expect_ev(KData, 8'hFF);
    expect_ev(KData, 8'h3C);
    send_frame(8'h00, 1'b1, BitClk);
    send_frame(8'hFF, 1'b1, BitClk);
    send_frame(8'h3C, 1'b1, BitClk);
    repeat (20) @(negedge clk_i);
    drain("back-to-back");

    // Start glitch: 5 ticks low, then high
    rx_i = 1'b0;
    repeat (20) @(negedge clk_i);
    check("glitch busy high", rx_busy_o, 1);
    rx_i = 1'b1;
    repeat (60) @(negedge clk_i);
    check("glitch busy low", rx_busy_o, 0);
    check("glitch no valid", rx_valid_o, 0);
    drain("glitch");

    // Framing error, stop bit released shortly after its mid-bit sample
    expect_ev(KFerr, 8'h00);
    expect_ev(KData, 8'h12);
    send_frame(8'h55, 1'b0, 40);
    repeat (128) @(negedge clk_i);
    check("ferr no valid", rx_valid_o, 0);
    send_frame(8'h12, 1'b1, BitClk);
    repeat (20) @(negedge clk_i);
    drain("framing error");

    // Overrun
    set_ready(1'b0);
    expect_ev(KOvr, 8'h22);
    send_frame(8'h11, 1'b1, BitClk);
    check("first held valid", rx_valid_o, 1);
    check("first held data", rx_data_o, 8'h11);
    send_frame(8'h22, 1'b1, BitClk);
    repeat (20) @(negedge clk_i);
    check("overrun valid", rx_valid_o, 1);
    check("overrun data", rx_data_o, 8'h22);
    expect_ev(KData, 8'h22);
    set_ready(1'b1);
    @(negedge clk_i);
    @(negedge clk_i);
    check("valid cleared", rx_valid_o, 0);
    drain("overrun");

    // Reset mid-frame during data bit 3 of 0xC3
    rx_i = 1'b0;
    repeat (BitClk) @(negedge clk_i);
    for (int i = 0; i < 3; i++) begin
      rx_i = (i < 2) ? 1'b1 : 1'b0;
      repeat (BitClk) @(negedge clk_i);
    end
    rx_i = 1'b0;
    repeat (32) @(negedge clk_i);
    check("busy mid-frame", rx_busy_o, 1);
    reset_i = 1'b1;
    rx_i    = 1'b1;
    repeat (3) @(negedge clk_i);
    check("mid reset busy", rx_busy_o, 0);
    check("mid reset data", rx_data_o, 0);
    check("mid reset valid", rx_valid_o, 0);
    reset_i = 1'b0;
    repeat (BitClk) @(negedge clk_i);
    expect_ev(KData, 8'h7E);
    send_frame(8'h7E, 1'b1, BitClk);
    repeat (20) @(negedge clk_i);
    drain("after reset");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver: recovers 8N1-style frames from an asynchronous `rx` line using the 16x oversampling tick from the baud rate generator. It sits between the board's serial input pin and the byte-stream consumer, for example the command parser or RX FIFO. It presents each received word on a valid/ready handshake and flags framing and overrun errors.

## Interface
- `DATA_BITS`, 8: data bits per frame, LSB first. Legal range 5–9.
- `OVERSAMPLE`, 16: ticks per bit period. Must match the generator; power of two.
- `clk` in 1: system clock. Single clock domain.
- `reset` in 1: synchronous, active-high reset.
- `tick` in 1: oversample strobe from the baud rate generator; one-`clk`-wide pulse.
- `rx` in 1: asynchronous serial input; idle high.
- `rx_ready` in 1: consumer accepts `rx_data` when high with `rx_valid`.
- `rx_data` out `DATA_BITS`: last good received word.
- `rx_valid` out 1: `rx_data` holds an unconsumed word.
- `frame_error` out 1: one-cycle pulse when a stop bit is sampled low.
- `overrun` out 1: one-cycle pulse when a word is overwritten before it is consumed.
- `rx_busy` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Input synchronizer.** `rx` passes through a 2-flop synchronizer; both flops reset to 1. All decisions use the synchronized value `rx_s`.
- **Registers.** Tick counter `s_cnt` (width log2(OVERSAMPLE)), bit counter `n_cnt`, shift register `shreg` (`DATA_BITS` wide).
- **FSM states:** IDLE, START, DATA, STOP. Reset enters IDLE with all counters at 0.
- **IDLE.** When `rx_s`==0, go to START and clear `s_cnt`. This transition does not wait for `tick`.
- **START.** On `tick`, if `s_cnt`==OVERSAMPLE/2−1, sample `rx_s`:
  - 0: go to DATA, clear `s_cnt` and `n_cnt`.
  - 1: glitch; return to IDLE with no flags.
  - Otherwise, increment `s_cnt`.
- **DATA.** On `tick`, if `s_cnt`==OVERSAMPLE−1:
  - Clear `s_cnt` and shift `rx_s` into the MSB of `shreg` (right shift, so the word ends up LSB first).
  - If `n_cnt`==DATA_BITS−1, go to STOP; else increment `n_cnt`.
  - Otherwise, increment `s_cnt`.
- **STOP.** On `tick`, if `s_cnt`==OVERSAMPLE−1, go to IDLE and:
  - `rx_s`==1: load `rx_data` from `shreg` and set `rx_valid`.
  - `rx_s`==0: pulse `frame_error`; `rx_data` and `rx_valid` are unchanged.
  - Otherwise, increment `s_cnt`.
- **Handshake.** `rx_valid && rx_ready` on a clock edge clears `rx_valid` on the next cycle. `rx_data` is held stable while `rx_valid` is high, except on overwrite (below).
- **Completion in the same cycle as a handshake.** New word loaded, `rx_valid` stays 1, no `overrun`.
- **Completion while `rx_valid` is high and `rx_ready` is low.** `rx_data` is overwritten with the new word, `rx_valid` stays 1, `overrun` pulses for one cycle.
- **Line break (rx held low).** Each frame time yields one `frame_error` pulse, then the FSM immediately re-enters START. No data is delivered.
- **No tick.** Without `tick` the FSM stalls in START, DATA or STOP; nothing times out.
- **Counter wrap.** Counters never wrap; they are cleared only by the explicit conditions above.

## Timing
- **Reset values:** `rx_data`=0, `rx_valid`=0, `frame_error`=0, `overrun`=0, `rx_busy`=0, state IDLE, synchronizer=1.
- **Reset mid-frame.** Frame is abandoned, no flags pulse, and all outputs return to reset values on the next edge.
- **Registered outputs.** All outputs are registered. `rx_valid`, `frame_error` and `overrun` change on the edge after the stop-bit sampling tick.
- **Sampling points:**
  - Start bit: at OVERSAMPLE/2 ticks after falling-edge detection.
  - Each data bit and the stop bit: OVERSAMPLE ticks after the previous sample, i.e. mid-bit.
- **Frame length.** From falling-edge detection to result: OVERSAMPLE/2 + (DATA_BITS+1)×OVERSAMPLE ticks. At defaults this is 8+144 = 152 ticks.
- **Synchronizer latency.** A falling edge on `rx` is seen by the FSM 2 `clk` cycles later.
- **Back-to-back frames.** Frames with a single stop bit must be received without loss. IDLE is re-entered half a bit before the stop bit ends.

## Test plan
- **Single word.** Send 0xA5 at 16 ticks/bit (tick every 4 clk), `rx_ready`=1 → `rx_valid` high for 1 cycle, `rx_data`=0xA5, no error pulses.
- **Back-to-back words.** Send 0x00, 0xFF, 0x3C with one stop bit each, `rx_ready`=1 → three valids in order with data 0x00, 0xFF, 0x3C.
- **Start glitch.** Drive `rx` low for 5 ticks, then high → FSM returns to IDLE, `rx_busy` falls, no `rx_valid` or `frame_error`.
- **Framing error.** Send 0x55 with stop bit 0 → `frame_error` pulses once, `rx_valid` stays 0. A following good 0x12 is then received correctly.
- **Overrun.** Hold `rx_ready`=0 and send 0x11, then 0x22 → `overrun` pulses at the second completion, `rx_data`=0x22, `rx_valid`=1. Raising `rx_ready` clears `rx_valid` the next cycle.
- **Reset mid-frame.** Assert `reset` during data bit 3 of 0xC3, release it, then send 0x7E → no output for 0xC3, `rx_data`=0x7E delivered.
